rf_sequencer: RTL
=================

# rf_sequencer

Issue/control stage sitting directly upstream of the 16x16-bit register file in the single-core processor. Accepts 16-bit instruction words over a valid/ready handshake and decodes the register fields. Sequences the register file through a read phase, an ALU execute phase and a write-back phase. It is the only driver of the register file's `rd` mode line, so reads and writes never overlap.

## Interface
Parameters:
- `DW`, 16: data width of register file and ALU.
- `AW`, 5: register-file address port width; decoded 4-bit fields are zero-extended into it.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `instr_in`  in  16  instruction word: [15:12] opcode, [11:8] rdst, [7:4] rs1, [3:0] rs2.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `rf_reg1`  out  AW  register file read address 1.
- `rf_reg2`  out  AW  register file read address 2.
- `rf_rdst`  out  AW  register file write address.
- `rf_rd`  out  1  1 = read mode, 0 = write mode.
- `rf_in`  out  DW  write data.
- `rf_out1`  in  DW  read data 1.
- `rf_out2`  in  DW  read data 2.
- `alu_op`  out  4  opcode presented to the ALU.
- `alu_a`  out  DW  first ALU operand.
- `alu_b`  out  DW  second ALU operand.
- `alu_valid`  out  1  operands valid.
- `alu_done`  in  1  result valid.
- `alu_result`  in  DW  result value.
- `halted`  out  1  HALT retired; sequencer frozen.
- `retired_count`  out  16  instructions retired.

## Operation
- States: IDLE, READ, EXEC, WRITE, HALT.
- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid`&`instr_ready`, latch the instruction.
  - Opcode 0x0 (NOP): stay in IDLE and increment `retired_count`.
  - Opcode 0xF (HALT): go to HALT and increment `retired_count`.
  - Any other opcode: go to READ.
- **READ**
  - Drive `rf_reg1`={0,rs1} and `rf_reg2`={0,rs2} with `rf_rd`=1.
  - At the end of the cycle, capture `rf_out1`/`rf_out2` into the operand registers.
  - Go to EXEC.
- **EXEC**
  - Assert `alu_valid`, `alu_op`, `alu_a` and `alu_b`; hold them stable until `alu_done`.
  - On `alu_done`, capture `alu_result`.
  - Go to WRITE.
- **WRITE**
  - `rf_rd`=0 for exactly one cycle, with `rf_rdst`={0,rdst} and `rf_in`=the captured result.
  - Increment `retired_count`.
  - Go to IDLE.
- **HALT**
  - `instr_ready`=0 and `halted`=1.
  - Leave only via reset.
- `rf_rd` is 1 in every state except WRITE, so the register file is never written by accident.
- `alu_done` while `alu_valid`=0 is ignored.
- `retired_count` wraps from 0xFFFF to 0x0000.
- rdst = rs1 or rs2 is legal: the read completes before the write.

## Timing
- All outputs are registered.
- `rf_rdst`, `rf_in` and `rf_rd`=0 change on the same edge (EXEC→WRITE).
- `rf_rd` returns to 1 on the WRITE→IDLE edge, with `rf_rdst` and `rf_in` held unchanged through that edge.
- Reset values:
  - state IDLE, `instr_ready`=1, `rf_rd`=1, `alu_valid`=0, `halted`=0.
  - `retired_count`=0.
  - all address and data outputs 0.
- Latency with `alu_done` on the first EXEC cycle: accept (cycle 0), READ (1), EXEC (2), WRITE (3), `instr_ready` again in cycle 4.
  - Throughput is one ALU instruction per 4 cycles.
  - Each ALU stall cycle adds one cycle.
- NOP throughput: one per cycle.
- Reset mid-operation, in any state:
  - Next state IDLE.
  - A pending write is discarded; `rf_rd` is 1 in the cycle after reset is sampled.
  - The in-flight instruction is not counted.
- `instr_valid` while `instr_ready`=0 is not consumed; upstream must hold the word.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (`OP_NOP`=4'h0, `OP_HALT`=4'hF)
  - instruction field bit positions
  - state enum for this block
- One sub-module, `instr_fields`: combinational slice of `instr_in` into opcode, rdst, rs1, rs2, plus `is_nop`/`is_halt` flags. It is reused by later decode stages.
- The FSM, operand registers and retire counter live in `rf_sequencer`.

## Test plan
- Reset, then idle:
  - `rf_rd`=1, `instr_ready`=1, `retired_count`=0, `halted`=0.
  - `rf_rd` never goes low over 20 cycles.
- `instr_in`=16'h1312 with a model register file holding mem[1]=2, mem[2]=3, and `alu_done` in the first EXEC cycle:
  - `alu_a`=2, `alu_b`=3, `alu_op`=1.
  - `rf_rd`=0 only in cycle 3, with `rf_rdst`=3 and `rf_in`=`alu_result`.
  - `instr_ready` returns in cycle 4; `retired_count`=1.
- `alu_done` delayed 5 cycles:
  - `alu_valid` and operands held stable for all 5 cycles.
  - Exactly one write occurs.
- Three back-to-back NOPs: accepted in 3 consecutive cycles, `retired_count`=3, no write cycle.
- HALT (16'hF000), then further valid instructions: `halted`=1, `instr_ready` stays 0, and `retired_count` is unchanged afterwards.
- `rst_n` low during EXEC, then during WRITE: next cycle IDLE with `rf_rd`=1 and `retired_count` not incremented.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, instruction field layout and the
// rf_sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int FIELD_W  = 4;
  localparam int OPC_LSB  = 12;
  localparam int RDST_LSB = 8;
  localparam int RS1_LSB  = 4;
  localparam int RS2_LSB  = 0;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } seq_state_e;

endpackage

// File: rtl/instr_fields.sv
// Combinational slice of an instruction word into its opcode and register
// fields, with flags for the two opcodes that never touch the register file.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] rdst,
  output logic [FIELD_W-1:0] rs1,
  output logic [FIELD_W-1:0] rs2,
  output logic               is_nop,
  output logic               is_halt
);

  assign opcode  = instr[OPC_LSB  +: FIELD_W];
  assign rdst    = instr[RDST_LSB +: FIELD_W];
  assign rs1     = instr[RS1_LSB  +: FIELD_W];
  assign rs2     = instr[RS2_LSB  +: FIELD_W];
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);

endmodule

// File: rtl/rf_sequencer.sv
// Issue/control stage in front of the register file: walks each ALU
// instruction through read, execute and a single write-back cycle.
module rf_sequencer
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [AW-1:0]      rf_reg1,
  output logic [AW-1:0]      rf_reg2,
  output logic [AW-1:0]      rf_rdst,
  output logic               rf_rd,
  output logic [DW-1:0]      rf_in,
  input  logic [DW-1:0]      rf_out1,
  input  logic [DW-1:0]      rf_out2,
  output logic [3:0]         alu_op,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic               alu_valid,
  input  logic               alu_done,
  input  logic [DW-1:0]      alu_result,
  output logic               halted,
  output logic [15:0]        retired_count
);

  function automatic logic [AW-1:0] zext(input logic [FIELD_W-1:0] f);
    return {{(AW-FIELD_W){1'b0}}, f};
  endfunction

  logic [FIELD_W-1:0] f_opcode, f_rdst, f_rs1, f_rs2;
  logic               f_is_nop, f_is_halt;

  instr_fields u_fields (
    .instr   (instr_in),
    .opcode  (f_opcode),
    .rdst    (f_rdst),
    .rs1     (f_rs1),
    .rs2     (f_rs2),
    .is_nop  (f_is_nop),
    .is_halt (f_is_halt)
  );

  seq_state_e state_reg, state_next;

  logic               instr_ready_reg, instr_ready_next;
  logic [AW-1:0]      rf_reg1_reg, rf_reg1_next;
  logic [AW-1:0]      rf_reg2_reg, rf_reg2_next;
  logic [AW-1:0]      rf_rdst_reg, rf_rdst_next;
  logic               rf_rd_reg, rf_rd_next;
  logic [DW-1:0]      rf_in_reg, rf_in_next;
  logic [3:0]         alu_op_reg, alu_op_next;
  logic [DW-1:0]      alu_a_reg, alu_a_next;
  logic [DW-1:0]      alu_b_reg, alu_b_next;
  logic               alu_valid_reg, alu_valid_next;
  logic               halted_reg, halted_next;
  logic [15:0]        retired_reg, retired_next;
  logic [FIELD_W-1:0] op_lat_reg, op_lat_next;
  logic [FIELD_W-1:0] rdst_lat_reg, rdst_lat_next;

  logic accept;
  assign accept = instr_valid && instr_ready_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (f_is_halt)     state_next = ST_HALT;
          else if (!f_is_nop) state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_EXEC;
      ST_EXEC:  if (alu_done) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Next values for every registered output; each state only touches what it owns.
  always_comb begin
    instr_ready_next = instr_ready_reg;
    rf_reg1_next     = rf_reg1_reg;
    rf_reg2_next     = rf_reg2_reg;
    rf_rdst_next     = rf_rdst_reg;
    rf_rd_next       = rf_rd_reg;
    rf_in_next       = rf_in_reg;
    alu_op_next      = alu_op_reg;
    alu_a_next       = alu_a_reg;
    alu_b_next       = alu_b_reg;
    alu_valid_next   = alu_valid_reg;
    halted_next      = halted_reg;
    retired_next     = retired_reg;
    op_lat_next      = op_lat_reg;
    rdst_lat_next    = rdst_lat_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (f_is_nop) begin
            retired_next = retired_reg + 16'd1;
          end else if (f_is_halt) begin
            retired_next     = retired_reg + 16'd1;
            halted_next      = 1'b1;
            instr_ready_next = 1'b0;
          end else begin
            instr_ready_next = 1'b0;
            rf_reg1_next     = zext(f_rs1);
            rf_reg2_next     = zext(f_rs2);
            op_lat_next      = f_opcode;
            rdst_lat_next    = f_rdst;
          end
        end
      end
      ST_READ: begin
        alu_a_next     = rf_out1;
        alu_b_next     = rf_out2;
        alu_op_next    = op_lat_reg;
        alu_valid_next = 1'b1;
      end
      ST_EXEC: begin
        if (alu_done) begin
          alu_valid_next = 1'b0;
          rf_in_next     = alu_result;
          rf_rdst_next   = zext(rdst_lat_reg);
          rf_rd_next     = 1'b0;
        end
      end
      ST_WRITE: begin
        // Address and data stay put so the write edge sees stable inputs.
        rf_rd_next       = 1'b1;
        retired_next     = retired_reg + 16'd1;
        instr_ready_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_ready_reg <= 1'b1;
      rf_reg1_reg     <= '0;
      rf_reg2_reg     <= '0;
      rf_rdst_reg     <= '0;
      rf_rd_reg       <= 1'b1;
      rf_in_reg       <= '0;
      alu_op_reg      <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_valid_reg   <= 1'b0;
      halted_reg      <= 1'b0;
      retired_reg     <= '0;
      op_lat_reg      <= '0;
      rdst_lat_reg    <= '0;
    end else begin
      instr_ready_reg <= instr_ready_next;
      rf_reg1_reg     <= rf_reg1_next;
      rf_reg2_reg     <= rf_reg2_next;
      rf_rdst_reg     <= rf_rdst_next;
      rf_rd_reg       <= rf_rd_next;
      rf_in_reg       <= rf_in_next;
      alu_op_reg      <= alu_op_next;
      alu_a_reg       <= alu_a_next;
      alu_b_reg       <= alu_b_next;
      alu_valid_reg   <= alu_valid_next;
      halted_reg      <= halted_next;
      retired_reg     <= retired_next;
      op_lat_reg      <= op_lat_next;
      rdst_lat_reg    <= rdst_lat_next;
    end
  end

  assign instr_ready   = instr_ready_reg;
  assign rf_reg1       = rf_reg1_reg;
  assign rf_reg2       = rf_reg2_reg;
  assign rf_rdst       = rf_rdst_reg;
  assign rf_rd         = rf_rd_reg;
  assign rf_in         = rf_in_reg;
  assign alu_op        = alu_op_reg;
  assign alu_a         = alu_a_reg;
  assign alu_b         = alu_b_reg;
  assign alu_valid     = alu_valid_reg;
  assign halted        = halted_reg;
  assign retired_count = retired_reg;

endmodule
